mpx_regfile_mp: RTL and testbench

Parametrised multi-port register file for the MPX core. It generalises the two-read, one-write register file to N read ports and two write ports: port 0 for pipeline writeback, port 1 for delayed load writeback. It adds optional same-cycle write-to-read bypass and a handshaked debug access port for host-side register reads and writes. It sits between decode/issue (reads) and writeback (writes), and the debug port is driven by the debug controller.

---
 rtl/mpx_regfile_pkg.sv | 15 +
 rtl/mpx_regfile_dbg.sv | 78 +++++++
 rtl/mpx_regfile_mp.sv | 94 +++++++++
 tb/tb_mpx_regfile_mp.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpx_regfile_pkg.sv
// Shared types and default sizes for the MPX multi-port register file.
// The debug FSM encoding is fixed here so the top and the debug block agree on it.
package mpx_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dbg_state_e;

  localparam int DEF_NUM_RD_PORTS = 2;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_NUM_REGS     = 32;

endpackage

// File: rtl/mpx_regfile_dbg.sv
// Debug access FSM: reads answer in 1 cycle; writes wait for a cycle with both pipeline
// write ports idle (pipeline always wins, no timeout), committing on the edge that enters ACK.
module mpx_regfile_dbg
  import mpx_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dbg_req_i,
  input  logic              dbg_wr_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              slot_free_i,
  input  logic [DATA_W-1:0] arr_rdata_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_we_o,
  output logic [ADDR_W-1:0] dbg_waddr_o,
  output logic [DATA_W-1:0] dbg_wdata_o
);

  dbg_state_e        state_q, state_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (dbg_req_i) begin
          if (!dbg_wr_i) begin
            rdata_d = arr_rdata_i;
            state_d = ACK;
          end else if (slot_free_i) begin
            we      = 1'b1;
            state_d = ACK;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (slot_free_i) begin
          we      = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // ack is registered so it is high exactly while the FSM sits in ACK
    ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign dbg_ack_o   = ack_q;
  assign dbg_rdata_o = rdata_q;
  assign dbg_we_o    = we;
  assign dbg_waddr_o = dbg_addr_i;
  assign dbg_wdata_o = dbg_wdata_i;

endmodule

// File: rtl/mpx_regfile_mp.sv
// Multi-port register file: N combinational read ports, two write ports (port 0 wins), debug port.
// MPX_REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding (port 0 > port 1 > array).
module mpx_regfile_mp
  import mpx_regfile_pkg::*;
#(
  parameter int  NUM_RD_PORTS = DEF_NUM_RD_PORTS,
  parameter int  DATA_W       = DEF_DATA_W,
  parameter int  NUM_REGS     = DEF_NUM_REGS,
  localparam int ADDR_W       = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_W-1:0]              rd0_i,
  input  logic [DATA_W-1:0]              rd0_value_i,
  input  logic [ADDR_W-1:0]              rd1_i,
  input  logic [DATA_W-1:0]              rd1_value_i,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] ra_i,
  output logic [NUM_RD_PORTS*DATA_W-1:0] ra_value_o,
  input  logic                           dbg_req_i,
  input  logic                           dbg_wr_i,
  input  logic [ADDR_W-1:0]              dbg_addr_i,
  input  logic [DATA_W-1:0]              dbg_wdata_i,
  output logic                           dbg_ack_o,
  output logic [DATA_W-1:0]              dbg_rdata_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              slot_free;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_waddr;
  logic [DATA_W-1:0] dbg_wdata;

  assign slot_free = (rd0_i == '0) && (rd1_i == '0);

  mpx_regfile_dbg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dbg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .dbg_req_i   (dbg_req_i),
    .dbg_wr_i    (dbg_wr_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .slot_free_i (slot_free),
    .arr_rdata_i (regs_q[dbg_addr_i]),
    .dbg_ack_o   (dbg_ack_o),
    .dbg_rdata_o (dbg_rdata_o),
    .dbg_we_o    (dbg_we),
    .dbg_waddr_o (dbg_waddr),
    .dbg_wdata_o (dbg_wdata)
  );

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd0_i == ADDR_W'(i)) begin
        regs_d[i] = rd0_value_i;
      end else if (rd1_i == ADDR_W'(i)) begin
        regs_d[i] = rd1_value_i;
      end else if (dbg_we && (dbg_waddr == ADDR_W'(i))) begin
        regs_d[i] = dbg_wdata;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic [DATA_W-1:0] arr_k;
    assign ra_k  = ra_i[k*ADDR_W +: ADDR_W];
    assign arr_k = (ra_k == '0) ? '0 : regs_q[ra_k];
`ifdef MPX_REGFILE_BYPASS_EN
    assign ra_value_o[k*DATA_W +: DATA_W] =
      ((ra_k != '0) && (ra_k == rd0_i)) ? rd0_value_i :
      ((ra_k != '0) && (ra_k == rd1_i)) ? rd1_value_i : arr_k;
`else
    assign ra_value_o[k*DATA_W +: DATA_W] = arr_k;
`endif
  end

endmodule

// File: tb/tb_mpx_regfile_mp.sv
// Bench for mpx_regfile_mp: table of per-cycle read/write vectors plus debug-port sequences.
module tb_mpx_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NP = 2;
`ifdef MPX_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [AW-1:0]   rd0_i, rd1_i;
  logic [DW-1:0]   rd0_value_i, rd1_value_i;
  logic [NP*AW-1:0] ra_i;
  logic [NP*DW-1:0] ra_value_o;
  logic            dbg_req_i, dbg_wr_i;
  logic [AW-1:0]   dbg_addr_i;
  logic [DW-1:0]   dbg_wdata_i;
  logic            dbg_ack_o;
  logic [DW-1:0]   dbg_rdata_o;

  always #5 clk_i = ~clk_i;

  mpx_regfile_mp dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd0_i       (rd0_i),
    .rd0_value_i (rd0_value_i),
    .rd1_i       (rd1_i),
    .rd1_value_i (rd1_value_i),
    .ra_i        (ra_i),
    .ra_value_o  (ra_value_o),
    .dbg_req_i   (dbg_req_i),
    .dbg_wr_i    (dbg_wr_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .dbg_ack_o   (dbg_ack_o),
    .dbg_rdata_o (dbg_rdata_o)
  );

  typedef struct {
    string         name;
    int            port;
    logic [DW-1:0] exp;
  } rd_exp_t;

  typedef struct {
    logic [AW-1:0] rd0;
    logic [DW-1:0] v0;
    logic [AW-1:0] rd1;
    logic [DW-1:0] v1;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;  // expected without forwarding
    logic [DW-1:0] e1;
    logic [DW-1:0] b0;  // expected with forwarding
    logic [DW-1:0] b1;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mdl [32];
  logic [DW-1:0] last_rd;
  rd_exp_t       rd_q[$];
  logic [DW-1:0] ack_q[$];
  vec_t          vec [10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rdport(input int k);
    return ra_value_o[k*DW +: DW];
  endfunction

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra_i = {a1, a0};
  endtask

  task automatic push_rd(input string name, input int port, input logic [DW-1:0] exp);
    rd_exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    rd_q.push_back(e);
  endtask

  task automatic drain_rd();
    rd_exp_t e;
    while (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      check(e.name, rdport(e.port), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Checks both read ports against the model at the next negedge.
  task automatic read_pair(input string name, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    set_ra(a0, a1);
    push_rd({name, ".p0"}, 0, mdl[a0]);
    push_rd({name, ".p1"}, 1, mdl[a1]);
    @(negedge clk_i);
    drain_rd();
    step();
  endtask

  task automatic dbg_txn(input string name, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int busy, input int exp_lat);
    int lat;
    bit seen;
    dbg_req_i   = 1'b1;
    dbg_wr_i    = wr;
    dbg_addr_i  = addr;
    dbg_wdata_i = wdata;
    if (!wr) last_rd = mdl[addr];
    ack_q.push_back(last_rd);
    if (busy > 0) begin
      rd0_i       = 5'd13;
      rd0_value_i = 32'h1300_0000;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk_i);
      if (rd0_i != '0) mdl[rd0_i] = rd0_value_i;
      #1;
      lat++;
      if (lat < busy) rd0_value_i = 32'h1300_0000 + DW'(lat);
      else rd0_i = '0;
      if (dbg_ack_o) seen = 1'b1;
    end
    check({name, " latency"}, DW'(lat), DW'(exp_lat));
    dbg_req_i = 1'b0;
    check({name, " rdata"}, dbg_rdata_o, ack_q.pop_front());
    if (wr && addr != '0) mdl[addr] = wdata;
    step();
    check({name, " ack_drop"}, DW'(dbg_ack_o), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ackcnt;

    vec[0] = '{5'd5,  32'h1234_5678, 5'd0,  32'h0,         5'd5,  5'd0,
               32'h0,         32'h0,         32'h1234_5678, 32'h0};
    vec[1] = '{5'd0,  32'h0,         5'd0,  32'h0,         5'd5,  5'd5,
               32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    vec[2] = '{5'd7,  32'hAAAA_0000, 5'd7,  32'h5555_FFFF, 5'd0,  5'd5,
               32'h0,         32'h1234_5678, 32'h0,         32'h1234_5678};
    vec[3] = '{5'd0,  32'hFFFF_FFFF, 5'd0,  32'h1111_1111, 5'd7,  5'd0,
               32'hAAAA_0000, 32'h0,         32'hAAAA_0000, 32'h0};
    vec[4] = '{5'd0,  32'h0,         5'd3,  32'h0000_DEAD, 5'd7,  5'd3,
               32'hAAAA_0000, 32'h0,         32'hAAAA_0000, 32'h0000_DEAD};
    vec[5] = '{5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd3,
               32'h0,         32'h0000_DEAD, 32'h0,         32'h0000_DEAD};
    vec[6] = '{5'd9,  32'hCAFE_F00D, 5'd12, 32'h0000_0055, 5'd3,  5'd12,
               32'h0000_DEAD, 32'h0,         32'h0000_DEAD, 32'h0000_0055};
    vec[7] = '{5'd0,  32'h0,         5'd0,  32'h0,         5'd9,  5'd12,
               32'hCAFE_F00D, 32'h0000_0055, 32'hCAFE_F00D, 32'h0000_0055};
    vec[8] = '{5'd21, 32'h0123_4567, 5'd20, 32'h0BAD_BEEF, 5'd20, 5'd21,
               32'h0,         32'h0,         32'h0BAD_BEEF, 32'h0123_4567};
    vec[9] = '{5'd0,  32'h0,         5'd0,  32'h0,         5'd21, 5'd20,
               32'h0123_4567, 32'h0BAD_BEEF, 32'h0123_4567, 32'h0BAD_BEEF};

    for (int i = 0; i < 32; i++) mdl[i] = '0;
    last_rd     = '0;
    rst_i       = 1'b1;
    rd0_i       = '0;
    rd1_i       = '0;
    rd0_value_i = '0;
    rd1_value_i = '0;
    dbg_req_i   = 1'b0;
    dbg_wr_i    = 1'b0;
    dbg_addr_i  = '0;
    dbg_wdata_i = '0;
    set_ra(5'd5, 5'd7);

    step();
    step();
    @(negedge clk_i);
    check("reset ra0", rdport(0), '0);
    check("reset ra1", rdport(1), '0);
    check("reset ack", DW'(dbg_ack_o), '0);
    check("reset rdata", dbg_rdata_o, '0);
    step();
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      rd0_i       = vec[i].rd0;
      rd0_value_i = vec[i].v0;
      rd1_i       = vec[i].rd1;
      rd1_value_i = vec[i].v1;
      set_ra(vec[i].ra0, vec[i].ra1);
      push_rd($sformatf("vec%0d.p0", i), 0, BYP ? vec[i].b0 : vec[i].e0);
      push_rd($sformatf("vec%0d.p1", i), 1, BYP ? vec[i].b1 : vec[i].e1);
      @(negedge clk_i);
      drain_rd();
      if (vec[i].rd1 != '0) mdl[vec[i].rd1] = vec[i].v1;
      if (vec[i].rd0 != '0) mdl[vec[i].rd0] = vec[i].v0;
      step();
    end
    rd0_i = '0;
    rd1_i = '0;

    dbg_txn("dbg_rd_r9", 1'b0, 5'd9, '0, 0, 1);
    dbg_txn("dbg_wr_r12_blocked", 1'b1, 5'd12, 32'h0000_0001, 4, 5);
    read_pair("after_blocked", 5'd12, 5'd13);
    dbg_txn("dbg_wr_r0", 1'b1, 5'd0, 32'hFFFF_FFFF, 0, 1);
    read_pair("r0_after_dbg", 5'd0, 5'd7);
    dbg_txn("dbg_wr_r22", 1'b1, 5'd22, 32'h2222_2222, 0, 1);
    dbg_txn("dbg_rd_r22", 1'b0, 5'd22, '0, 0, 1);

    // Debug write parked in WAIT, then reset mid-cycle.
    set_ra(5'd9, 5'd12);
    dbg_req_i   = 1'b1;
    dbg_wr_i    = 1'b1;
    dbg_addr_i  = 5'd14;
    dbg_wdata_i = 32'h0000_ABCD;
    rd0_i       = 5'd15;
    rd0_value_i = 32'h0000_F00F;
    ackcnt      = 0;
    step();
    if (dbg_ack_o) ackcnt++;
    step();
    if (dbg_ack_o) ackcnt++;
    #3;
    rst_i = 1'b1;
    #1;
    check("async_rst ra0", rdport(0), '0);
    check("async_rst ra1", rdport(1), '0);
    check("async_rst rdata", dbg_rdata_o, '0);
    dbg_req_i = 1'b0;
    rd0_i     = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    last_rd = '0;
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dbg_ack_o) ackcnt++;
      step();
    end
    check("wait_rst no_ack", DW'(ackcnt), '0);
    read_pair("wait_rst regs", 5'd14, 5'd15);
    dbg_txn("dbg_rd_after_rst", 1'b0, 5'd14, '0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
